// File: rtl/sparse_pkg.sv
// Shared types for the sparse MAC datapath: operand pair, MAC state encoding
// and the zero-operand test used by the skip logic.
package sparse_pkg;

  localparam int SP_DATA_W = 8;

  typedef struct packed {
    logic signed [SP_DATA_W-1:0] a;
    logic signed [SP_DATA_W-1:0] b;
  } pair_t;

  typedef enum logic [1:0] {ACCUM, DRAIN, RESULT} mac_state_e;

  function automatic logic pair_nz(input pair_t p);
    return (p.a != '0) && (p.b != '0);
  endfunction

endpackage

// File: rtl/sparse_rr_arbiter.sv
// Round-robin one-hot arbiter; priority starts one past the last granted index.
// The pointer resets to N-1 so slot 0 wins first, and moves only on advance.
module sparse_rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q, ptr_d;

  // Scan lowest to highest priority so the last hit is the winner.
  always_comb begin
    int j;
    grant   = '0;
    gnt_idx = '0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(ptr_q) + k) % N;
      if (req[j]) begin
        grant   = N'(1) << j;
        gnt_idx = IW'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && (req != '0)) ptr_d = gnt_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= IW'(N - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sparse_mac_rr.sv
// N-slot sparse multiply-accumulate: round-robin issue, zero-operand skip,
// two-stage mul/acc pipeline, flush/drain/result FSM. SPARSE_MAC_SAT_EN clamps the add.
module sparse_mac_rr
  import sparse_pkg::*;
#(
  parameter int N     = 4,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  pair_t [N-1:0]        in_pair,
  output logic [N-1:0]         in_ready,
  input  logic                 flush,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ACC_W-1:0]     res_data,
  output logic [CNT_W-1:0]     res_count,
  output logic                 res_sat,
  output logic                 busy
);

  localparam int PW = 2 * SP_DATA_W;
  localparam int IW = $clog2(N);

  mac_state_e              state_q, state_d;
  logic [N-1:0]            occ_q, occ_d;
  pair_t [N-1:0]           pair_q, pair_d;
  logic                    s1_v_q, s1_v_d;
  logic signed [PW-1:0]    s1_p_q, s1_p_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sat_set;

  logic [N-1:0]  grant;
  logic [IW-1:0] gnt_idx;
  logic          any_gnt;
  pair_t         gnt_pair;

  // Slot array; a slot being granted is still occupied, so it cannot refill that cycle.
  for (genvar i = 0; i < N; i++) begin : g_slot
    assign in_ready[i] = rst_n && !occ_q[i] && (state_q == ACCUM);
    assign occ_d[i]    = (occ_q[i] && !grant[i]) || (in_valid[i] && in_ready[i]);
    assign pair_d[i]   = (in_valid[i] && in_ready[i]) ? in_pair[i] : pair_q[i];
  end

  sparse_rr_arbiter #(.N(N)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (occ_q),
    .advance (any_gnt),
    .grant   (grant),
    .gnt_idx (gnt_idx)
  );

  assign any_gnt  = |grant;
  assign gnt_pair = pair_q[gnt_idx];
  assign s1_v_d   = any_gnt && pair_nz(gnt_pair);
  assign s1_p_d   = PW'(gnt_pair.a) * PW'(gnt_pair.b);

`ifdef SPARSE_MAC_SAT_EN
  localparam int SW = ACC_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [SW-1:0] sum_w;
  logic                 sat_q, sat_d;

  // One guard bit: overflow whenever the two top bits of the wide sum disagree.
  always_comb begin
    sum_w   = SW'(acc_q) + SW'(s1_p_q);
    sat_set = sum_w[SW-1] != sum_w[SW-2];
    acc_sum = sum_w[ACC_W-1:0];
    if (sat_set) acc_sum = sum_w[SW-1] ? ACC_MIN : ACC_MAX;
  end

  always_comb begin
    sat_d = sat_q;
    if (s1_v_q && sat_set) sat_d = 1'b1;
    if (state_q == RESULT && res_ready) sat_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= 1'b0;
    else        sat_q <= sat_d;
  end

  assign res_sat = sat_q;
`else
  assign sat_set = 1'b0;
  assign acc_sum = acc_q + ACC_W'(s1_p_q);
  assign res_sat = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (s1_v_q) begin
      acc_d = acc_sum;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
    case (state_q)
      ACCUM:   if (flush) state_d = DRAIN;
      DRAIN:   if ((occ_q == '0) && !s1_v_q) state_d = RESULT;
      RESULT: begin
        if (res_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      occ_q   <= '0;
      pair_q  <= '0;
      s1_v_q  <= 1'b0;
      s1_p_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      pair_q  <= pair_d;
      s1_v_q  <= s1_v_d;
      s1_p_q  <= s1_p_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign res_valid = (state_q == RESULT);
  assign res_data  = acc_q;
  assign res_count = cnt_q;
  assign busy      = (state_q != ACCUM);

endmodule

// File: tb/tb_sparse_mac_rr.sv
// Directed bench for sparse_mac_rr with a transaction-level dot-product model
// checked on every result cycle, plus literal expectations for each scenario.
module tb_sparse_mac_rr;
  import sparse_pkg::*;

  localparam int N     = 4;
  localparam int ACC_W = 16;
  localparam int CNT_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      in_valid;
  pair_t [N-1:0]     in_pair;
  logic [N-1:0]      in_ready;
  logic              flush;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic [CNT_W-1:0]  res_count;
  logic              res_sat;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  sparse_mac_rr #(.N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pair(in_pair),
    .in_ready(in_ready), .flush(flush), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_count(res_count),
    .res_sat(res_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic pair_t mk(input int a, input int b);
    pair_t p;
    p.a = SP_DATA_W'(a);
    p.b = SP_DATA_W'(b);
    return p;
  endfunction

  // Model: the result is the (wrapped or clamped) sum of the products of every
  // accepted non-zero pair since the last result handshake.
  longint m_data;
  int     m_cnt;
  bit     m_sat;

  function automatic void m_add(input longint p);
    longint s, lim, mod;
    lim = longint'(1) << (ACC_W - 1);
    mod = longint'(1) << ACC_W;
    s = m_data + p;
`ifdef SPARSE_MAC_SAT_EN
    if (s > lim - 1) begin s = lim - 1; m_sat = 1'b1; end
    else if (s < -lim) begin s = -lim; m_sat = 1'b1; end
`else
    s = s & (mod - 1);
    if (s >= lim) s = s - mod;
`endif
    m_data = s;
    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data = 0; m_cnt = 0; m_sat = 1'b0;
    end else begin
      if (res_valid && res_ready) begin
        m_data = 0; m_cnt = 0; m_sat = 1'b0;
      end
      for (int i = 0; i < N; i++)
        if (in_valid[i] && in_ready[i] && in_pair[i].a != 0 && in_pair[i].b != 0)
          m_add(longint'(in_pair[i].a) * longint'(in_pair[i].b));
    end
  end

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      chk("rst_in_ready", longint'(in_ready), 0);
      chk("rst_res_valid", longint'(res_valid), 0);
    end else if (res_valid) begin
      chk("mdl_data", longint'($signed(res_data)), m_data);
      chk("mdl_count", longint'(res_count), longint'(m_cnt));
      chk("mdl_sat", longint'(res_sat), longint'(m_sat));
      chk("mdl_rdy_low", longint'(in_ready), 0);
      chk("mdl_busy", longint'(busy), 1);
    end
  end

  task automatic wait_res(input int maxc);
    int c;
    c = 0;
    while (!res_valid && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (!res_valid) chk("res_timeout", 0, 1);
  endtask

  task automatic take();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("hs_valid_drop", longint'(res_valid), 0);
    chk("hs_ready_rise", longint'(in_ready), 4'hF);
  endtask

  initial begin
    logic [N-1:0] rr_exp [5];
    in_valid = '0; in_pair = '0; flush = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", longint'(in_ready), 0);
    chk("rst_data", longint'(res_data), 0);
    chk("rst_count", longint'(res_count), 0);
    chk("rst_sat", longint'(res_sat), 0);
    chk("rst_busy", longint'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", longint'(in_ready), 4'hF);

    // Round-robin order seen through in_ready re-opening one slot per cycle.
    in_valid = 4'hF;
    in_pair[0] = mk(1, 2); in_pair[1] = mk(3, 4);
    in_pair[2] = mk(-5, 6); in_pair[3] = mk(7, -1);
    rr_exp[0] = 4'h0; rr_exp[1] = 4'h1; rr_exp[2] = 4'h3;
    rr_exp[3] = 4'h7; rr_exp[4] = 4'hF;
    @(negedge clk);
    in_valid = '0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk("rr_order", longint'(in_ready), longint'(rr_exp[c]));
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_res(20);
    chk("rr_data", longint'($signed(res_data)), -23);
    chk("rr_count", longint'(res_count), 4);
    take();

    // Zero skip.
    in_valid = 4'h7;
    in_pair[0] = mk(0, 9); in_pair[1] = mk(2, 0); in_pair[2] = mk(3, 3);
    @(negedge clk);
    in_valid = '0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_res(20);
    chk("zs_data", longint'($signed(res_data)), 9);
    chk("zs_count", longint'(res_count), 1);
    take();

    // Empty flush: one DRAIN cycle, then result; then hold backpressure.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("ef_drain_valid", longint'(res_valid), 0);
    chk("ef_drain_busy", longint'(busy), 1);
    @(negedge clk);
    chk("ef_valid", longint'(res_valid), 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", longint'(res_valid), 1);
      chk("bp_data", longint'(res_data), 0);
      chk("bp_count", longint'(res_count), 0);
      chk("bp_ready", longint'(in_ready), 0);
    end
    take();
    chk("hs_busy", longint'(busy), 0);

    // Accumulator overflow: clamp or wrap depending on build.
    in_valid = 4'h7;
    in_pair[0] = mk(127, 127); in_pair[1] = mk(127, 127); in_pair[2] = mk(127, 127);
    @(negedge clk);
    in_valid = '0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_res(20);
`ifdef SPARSE_MAC_SAT_EN
    chk("sat_data", longint'($signed(res_data)), 32767);
    chk("sat_flag", longint'(res_sat), 1);
`else
    chk("wrap_data", longint'($signed(res_data)), -17149);
    chk("wrap_flag", longint'(res_sat), 0);
`endif
    take();

    // Reset while draining with two slots still occupied.
    in_valid = 4'hF;
    in_pair[0] = mk(1, 1); in_pair[1] = mk(2, 2);
    in_pair[2] = mk(3, 3); in_pair[3] = mk(4, 4);
    flush = 1'b1;
    @(negedge clk);
    in_valid = '0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("drain_busy", longint'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", longint'(res_valid), 0);
    chk("mr_busy", longint'(busy), 0);
    chk("mr_count", longint'(res_count), 0);
    chk("mr_data", longint'(res_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_ready", longint'(in_ready), 4'hF);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_res(20);
    chk("mr_flush_data", longint'(res_data), 0);
    chk("mr_flush_count", longint'(res_count), 0);
    take();

    // Fairness: slots 0 and 2 refilled whenever free; one grant every cycle.
    in_valid = 4'b0101;
    in_pair[0] = mk(2, 3); in_pair[2] = mk(-1, 4);
    @(negedge clk);
    chk("fair_start", longint'(in_ready), 4'b1010);
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      chk("fair_alt", longint'(in_ready), (c % 2 == 0) ? 4'b1011 : 4'b1110);
    end
    in_valid = '0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_res(20);
    chk("fair_data", longint'($signed(res_data)), 12);
    chk("fair_count_sat", longint'(res_count), 7);
    take();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
